// File: rtl/ctl_unit_pkg.sv
// Shared definitions for the field-sequencing control unit: state encoding and width helpers.
package ctl_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITRX,
    ST_CLEAR,
    ST_INIT,
    ST_VALIDCHK,
    ST_ISVALID,
    ST_TOUT
  } state_t;

  localparam int unsigned MAX_FIELDS = 16;

  // Index width for n fields; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Timer width able to hold 0..limit; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ctl_timeout_cnt.sv
// Saturating wait timer; expired flags the final permitted cycle of a wait.
module ctl_timeout_cnt
  import ctl_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A zero limit disables the timeout entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

endmodule

// File: rtl/ctl_unit_field_seq.sv
// Control FSM capturing NUM_FIELDS received bytes per operation, then checking the stop field.
module ctl_unit_field_seq
  import ctl_unit_pkg::*;
#(
  parameter int unsigned NUM_FIELDS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                RXINT,
  input  logic                                VALIDOP,
  input  logic                                VALIDSTOP,
  output logic                                CLEARFLAG,
  output logic [NUM_FIELDS-1:0]               INITFLAG,
  output logic [idx_width(NUM_FIELDS)-1:0]    FIELDIDX,
  output logic                                VALIDSTOPFLAG,
  output logic                                STOPERRFLAG,
  output logic                                TIMEOUTFLAG,
  output logic                                UNLOCKPASTFLAG,
  output logic                                BUSY
);

  localparam int unsigned IDX_W = idx_width(NUM_FIELDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic             expired;
  logic             tmr_clr;
  logic             tmr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if ((state == ST_IDLE) && VALIDOP) begin
      idx <= '0;
    end else if ((state == ST_INIT) && (idx != LAST_IDX)) begin
      idx <= idx + 1'b1;
    end
  end

  // Clearing on any cycle whose successor is not WAITRX keeps the timer at 0 outside waits.
  assign tmr_clr = reset || (state_next != ST_WAITRX);
  assign tmr_en  = (state == ST_WAITRX);

  ctl_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_comb begin
    state_next     = state;
    CLEARFLAG      = 1'b0;
    INITFLAG       = '0;
    VALIDSTOPFLAG  = 1'b0;
    STOPERRFLAG    = 1'b0;
    TIMEOUTFLAG    = 1'b0;
    UNLOCKPASTFLAG = 1'b0;
    BUSY           = 1'b1;
    case (state)
      ST_IDLE: begin
        UNLOCKPASTFLAG = 1'b1;
        BUSY           = 1'b0;
        if (VALIDOP) begin
          state_next = ST_WAITRX;
        end
      end
      ST_WAITRX: begin
        if (RXINT) begin
          state_next = ST_CLEAR;
        end else if (expired) begin
          state_next = ST_TOUT;
        end
      end
      ST_CLEAR: begin
        CLEARFLAG  = 1'b1;
        state_next = ST_INIT;
      end
      ST_INIT: begin
        INITFLAG[idx] = 1'b1;
        state_next    = (idx == LAST_IDX) ? ST_VALIDCHK : ST_WAITRX;
      end
      ST_VALIDCHK: begin
        if (VALIDSTOP) begin
          state_next = ST_ISVALID;
        end else begin
          STOPERRFLAG = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_ISVALID: begin
        VALIDSTOPFLAG = 1'b1;
        state_next    = ST_IDLE;
      end
      ST_TOUT: begin
        TIMEOUTFLAG = 1'b1;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign FIELDIDX = idx;

endmodule

// File: tb/tb_ctl_unit_field_seq.sv
// Randomized bench: per-operation expected output timelines are computed from the field timing rules.
module tb_ctl_unit_field_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, rx, op, stop;
  int   sel;

  logic a_rx, a_op, a_stop, b_rx, b_op, b_stop;
  assign a_rx   = (sel == 0) && rx;
  assign a_op   = (sel == 0) && op;
  assign a_stop = (sel == 0) && stop;
  assign b_rx   = (sel == 1) && rx;
  assign b_op   = (sel == 1) && op;
  assign b_stop = (sel == 1) && stop;

  logic       a_clr, a_vsf, a_serr, a_tout, a_unlock, a_busy;
  logic [1:0] a_init;
  logic [0:0] a_idx;
  logic       b_clr, b_vsf, b_serr, b_tout, b_unlock, b_busy;
  logic [3:0] b_init;
  logic [1:0] b_idx;

  ctl_unit_field_seq #(.NUM_FIELDS(2), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset(reset), .RXINT(a_rx), .VALIDOP(a_op), .VALIDSTOP(a_stop),
    .CLEARFLAG(a_clr), .INITFLAG(a_init), .FIELDIDX(a_idx), .VALIDSTOPFLAG(a_vsf),
    .STOPERRFLAG(a_serr), .TIMEOUTFLAG(a_tout), .UNLOCKPASTFLAG(a_unlock), .BUSY(a_busy)
  );

  ctl_unit_field_seq #(.NUM_FIELDS(4), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .RXINT(b_rx), .VALIDOP(b_op), .VALIDSTOP(b_stop),
    .CLEARFLAG(b_clr), .INITFLAG(b_init), .FIELDIDX(b_idx), .VALIDSTOPFLAG(b_vsf),
    .STOPERRFLAG(b_serr), .TIMEOUTFLAG(b_tout), .UNLOCKPASTFLAG(b_unlock), .BUSY(b_busy)
  );

  int errors = 0;
  int checks = 0;
  int hold[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Layout: busy,unlock,clear,validstop,stoperr,timeout | 6'b0 | initflag[15:0] | fieldidx[3:0]
  function automatic logic [31:0] pk(input bit busy, input bit clr, input int init_bit,
                                     input bit vsf, input bit serr, input bit tout, input int idx);
    logic [15:0] ini;
    ini = '0;
    if (init_bit >= 0) ini[init_bit] = 1'b1;
    return {busy, ~busy, clr, vsf, serr, tout, 6'b0, ini, 4'(idx)};
  endfunction

  function automatic logic [31:0] observe();
    if (sel == 0)
      return {a_busy, a_unlock, a_clr, a_vsf, a_serr, a_tout, 6'b0, 14'b0, a_init, 3'b0, a_idx};
    return {b_busy, b_unlock, b_clr, b_vsf, b_serr, b_tout, 6'b0, 12'b0, b_init, 2'b0, b_idx};
  endfunction

  // One operation: gaps are WAITRX cycles before RXINT per field; rst_at<0 means no reset.
  task automatic run_op(input int s, input int g0, input int g1, input int g2, input int g3,
                        input bit sv, input int rst_at, input string tag);
    int nf, to, n, w, r, vc, fin;
    int g[4];
    logic [31:0] e[256];
    bit rxv[256], opv[256], stv[256], rsv[256], inwait[256];
    nf = (s != 0) ? 4 : 2;
    to = (s != 0) ? 0 : 8;
    g = '{g0, g1, g2, g3};
    sel = s;
    for (int m = 0; m < 256; m++) begin
      e[m] = pk(0, 0, -1, 0, 0, 0, hold[s]);
      rxv[m] = 0; opv[m] = 0; stv[m] = 0; rsv[m] = 0; inwait[m] = 0;
    end
    n = 1; vc = -1; fin = 0;
    for (int k = 0; k < nf; k++) begin
      w = n;
      if (to > 0 && g[k] >= to) begin
        for (int j = w; j < w + to; j++) begin
          e[j] = pk(1, 0, -1, 0, 0, 0, k);
          inwait[j] = 1;
        end
        e[w + to] = pk(1, 0, -1, 0, 0, 1, k);
        fin = w + to + 1;
        hold[s] = k;
        break;
      end
      r = w + g[k];
      for (int j = w; j <= r; j++) begin
        e[j] = pk(1, 0, -1, 0, 0, 0, k);
        inwait[j] = 1;
      end
      rxv[r] = 1;
      e[r + 1] = pk(1, 1, -1, 0, 0, 0, k);
      e[r + 2] = pk(1, 0, k, 0, 0, 0, k);
      if (k < nf - 1) begin
        n = r + 3;
      end else begin
        vc = r + 3;
        e[vc] = pk(1, 0, -1, 0, !sv, 0, nf - 1);
        if (sv) begin
          e[vc + 1] = pk(1, 0, -1, 1, 0, 0, nf - 1);
          fin = vc + 2;
        end else begin
          fin = vc + 1;
        end
        hold[s] = nf - 1;
      end
    end
    e[fin] = pk(0, 0, -1, 0, 0, 0, hold[s]);
    for (int m = 0; m <= fin; m++) begin
      if (!inwait[m]) rxv[m] = ($urandom % 3) == 0;
      if (m > 0) opv[m] = ($urandom % 3) == 0;
      stv[m] = ($urandom % 2) == 0;
    end
    opv[0] = 1;
    if (vc >= 0) begin
      stv[vc - 1] = sv;
      stv[vc] = sv;
    end
    if (rst_at >= 0 && rst_at < fin) begin
      rsv[rst_at] = 1;
      fin = rst_at + 1;
      hold[0] = 0;
      hold[1] = 0;
      e[fin] = pk(0, 0, -1, 0, 0, 0, 0);
    end
    opv[fin] = 0;
    for (int m = 0; m <= fin; m++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, m), observe(), e[m]);
      rx = rxv[m]; op = opv[m]; stop = stv[m]; reset = rsv[m];
    end
    rx = 0; op = 0; reset = 0;
  endtask

  initial begin
    int s, rst_at;
    reset = 1; rx = 0; op = 0; stop = 0; sel = 0;
    hold[0] = 0; hold[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 0; #1 check("reset_a", observe(), pk(0, 0, -1, 0, 0, 0, 0));
    sel = 1; #1 check("reset_b", observe(), pk(0, 0, -1, 0, 0, 0, 0));
    reset = 0;

    run_op(0, 2, 1, 0, 0, 1, -1, "two_field");
    run_op(1, 2, 2, 2, 2, 0, -1, "four_field_stoperr");
    run_op(0, 20, 0, 0, 0, 1, -1, "timeout");
    run_op(0, 7, 7, 0, 0, 1, -1, "rx_at_limit");
    run_op(0, 3, 10, 0, 0, 0, -1, "second_field_timeout");
    run_op(0, 2, 1, 0, 0, 1, 4, "reset_in_clear");
    run_op(1, 11, 0, 11, 5, 1, -1, "no_timeout_limit");

    repeat (40) begin
      s = int'($urandom % 2);
      rst_at = (($urandom % 4) == 0) ? int'($urandom_range(30, 0)) : -1;
      run_op(s, int'($urandom_range(11, 0)), int'($urandom_range(11, 0)),
             int'($urandom_range(11, 0)), int'($urandom_range(11, 0)),
             bit'($urandom % 2), rst_at, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
